// File: rtl/hazard_log_writer_if.sv
// ============================================================================
// Module      : hazard_log_writer_if
// Description : Drain port of the RAW-hazard log. The writer drives the
//               head entry, its valid flag and the fill level; the reader
//               drives log_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_log_writer_if #(
  parameter int SEQ_W = 8,
  parameter int DEPTH = 8
);
  logic                     log_valid;
  logic                     log_ready;
  logic [SEQ_W+3:0]         log_data;
  logic [$clog2(DEPTH):0]   log_count;

  modport master (
    output log_valid,
    output log_data,
    output log_count,
    input  log_ready
  );

  modport slave (
    input  log_valid,
    input  log_data,
    input  log_count,
    output log_ready
  );
endinterface

`default_nettype wire

// File: rtl/hazard_log_writer.sv
// ============================================================================
// Module      : hazard_log_writer
// Description : Producer side of the RAW-hazard log for the 5-stage pipeline.
//               Compares ID source registers against EX/MEM destinations,
//               flags hazards and logs one entry per hazarded instruction
//               into a show-ahead circular buffer drained via logIf.
//               Optional macro HAZARD_LOG_DISPLAY_EN prints each logged entry
//               in simulation; hardware is identical either way.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_log_writer #(
  parameter int REG_AW = 3,
  parameter int SEQ_W  = 8,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clear,
  input  wire logic              id_valid,
  input  wire logic              id_advance,
  input  wire logic [REG_AW-1:0] id_rs1,
  input  wire logic [REG_AW-1:0] id_rs2,
  input  wire logic [REG_AW-1:0] ex_rd,
  input  wire logic              ex_regwrite,
  input  wire logic [REG_AW-1:0] mem_rd,
  input  wire logic              mem_regwrite,
  output logic                   hazard_now,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  hazard_log_writer_if.master    logIf
);

  localparam int                  c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]    c_FULL_CNT = (c_PTR_W+1)'(DEPTH);

  // Storage and bookkeeping
  logic [SEQ_W+3:0]     r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [c_PTR_W:0]     r_count;
  logic [SEQ_W-1:0]     r_seq;
  logic                 r_logged;
  logic                 r_overflow;
  logic [DROP_W-1:0]    r_dropCount;

  // Hazard detection
  logic w_ex1, w_mem1, w_ex2, w_mem2;
  logic w_rs1Hit, w_rs1Dist, w_rs2Hit, w_rs2Dist;
  logic w_push, w_pop, w_full, w_write, w_drop;
  logic [SEQ_W+3:0] w_entry;

  // Compare each ID source against both in-flight producers
  always_comb begin
    w_ex1      = ex_regwrite  && (ex_rd  == id_rs1);
    w_mem1     = mem_regwrite && (mem_rd == id_rs1);
    w_ex2      = ex_regwrite  && (ex_rd  == id_rs2);
    w_mem2     = mem_regwrite && (mem_rd == id_rs2);
    w_rs1Hit   = w_ex1 | w_mem1;
    w_rs2Hit   = w_ex2 | w_mem2;
    // Nearest producer wins; a source with no hit reports distance 0
    w_rs1Dist  = !w_ex1 && w_mem1;
    w_rs2Dist  = !w_ex2 && w_mem2;
    hazard_now = id_valid && (w_rs1Hit || w_rs2Hit);
    w_entry    = {r_seq, w_rs1Hit, w_rs1Dist, w_rs2Hit, w_rs2Dist};
    w_push     = hazard_now && !r_logged;
    w_pop      = (r_count != '0) && logIf.log_ready;
    w_full     = (r_count == c_FULL_CNT);
    // A full buffer still accepts an entry if the head leaves in the same cycle
    w_write    = w_push && (!w_full || w_pop);
    w_drop     = w_push && w_full && !w_pop;
  end

  // Buffer storage; clear and reset discard the in-flight entry
  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_write) begin
      r_mem[r_wrPtr] <= w_entry;
    end
  end

  // Pointers, fill level, sequence tracking and drop statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_seq       <= '0;
      r_logged    <= 1'b0;
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      if (id_valid && id_advance) begin
        r_seq <= r_seq + 1'b1;
      end
      // Advance wins over a coincident push so the next instruction can log
      if (id_advance) begin
        r_logged <= 1'b0;
      end else if (w_push) begin
        r_logged <= 1'b1;
      end

      if (clear) begin
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_dropCount <= '0;
      end else begin
        if (w_write) begin
          r_wrPtr <= r_wrPtr + 1'b1;
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
        if (w_write && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (!w_write && w_pop) begin
          r_count <= r_count - 1'b1;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_dropCount != '1) begin
            r_dropCount <= r_dropCount + 1'b1;
          end
        end
      end
    end
  end

`ifdef HAZARD_LOG_DISPLAY_EN
  // Simulation trace of every entry that lands in the buffer
  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_write) begin
      $display("%b %b -- RAW seq=%0d", w_rs1Hit, w_rs2Hit, r_seq);
    end
  end
`else
  // Trace disabled: no simulation printing
`endif

  assign logIf.log_valid = (r_count != '0);
  assign logIf.log_data  = r_mem[r_rdPtr];
  assign logIf.log_count = r_count;
  assign overflow        = r_overflow;
  assign drop_count      = r_dropCount;

endmodule

`default_nettype wire

// File: tb/tb_hazard_log_writer.sv
// ============================================================================
// Module      : tb_hazard_log_writer
// Description : Directed table-driven bench for hazard_log_writer plus
//               hand-written multi-cycle sequences (overflow, saturation,
//               clear, seq wrap, mid-operation reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_log_writer;

  logic       clk = 1'b0;
  logic       rst_n, clear, idValid, idAdvance;
  logic [2:0] idRs1, idRs2, exRd, memRd;
  logic       exRegwrite, memRegwrite;
  logic       hazardNow, overflow;
  logic [7:0] dropCount;

  int nVec = 0;
  int nMis = 0;
  int expSeq;

  hazard_log_writer_if #(.SEQ_W(8), .DEPTH(8)) logIf ();

  hazard_log_writer #(.REG_AW(3), .SEQ_W(8), .DEPTH(8), .DROP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .id_valid     (idValid),
    .id_advance   (idAdvance),
    .id_rs1       (idRs1),
    .id_rs2       (idRs2),
    .ex_rd        (exRd),
    .ex_regwrite  (exRegwrite),
    .mem_rd       (memRd),
    .mem_regwrite (memRegwrite),
    .hazard_now   (hazardNow),
    .overflow     (overflow),
    .drop_count   (dropCount),
    .logIf        (logIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, iv, adv;
    logic [2:0] rs1, rs2, er;
    logic       ew;
    logic [2:0] mr;
    logic       mw, rdy;
    logic       hz;
    logic       lv;
    logic [3:0] cnt;
    logic       chkD;
    logic [11:0] data;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, iv, adv, input logic [2:0] r1, r2, er,
                       input logic ew, input logic [2:0] mr, input logic mw, rdy);
    clear       = c;
    idValid     = iv;
    idAdvance   = adv;
    idRs1       = r1;
    idRs2       = r2;
    exRd        = er;
    exRegwrite  = ew;
    memRd       = mr;
    memRegwrite = mw;
    logIf.log_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Simple EX hit on rs1; entry low nibble is 4'b1000
  task automatic hzPush(input logic adv, input logic rdy);
    drive(1'b0, 1'b1, adv, 3'd3, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, rdy);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    //            clr iv adv rs1 rs2 er ew mr mw rdy | hz lv cnt chkD data
    vecs[0]  = '{0,1,0,3,0,3,1,0,0,0, 1,1,1,1,12'h008};
    vecs[1]  = '{0,1,0,3,0,3,1,0,0,0, 1,1,1,1,12'h008};
    vecs[2]  = '{0,1,0,3,0,3,1,0,0,0, 1,1,1,1,12'h008};
    vecs[3]  = '{0,1,0,3,0,3,1,0,0,0, 1,1,1,1,12'h008};
    vecs[4]  = '{0,1,1,3,0,3,1,0,0,0, 1,1,1,1,12'h008};
    vecs[5]  = '{0,1,0,2,5,2,1,5,1,0, 1,1,2,1,12'h008};
    vecs[6]  = '{0,0,0,2,5,2,1,5,1,1, 0,1,1,1,12'h01B};
    vecs[7]  = '{0,1,1,4,7,4,1,4,1,1, 1,0,0,0,12'h000};
    vecs[8]  = '{0,1,1,4,7,4,1,4,1,1, 1,1,1,1,12'h028};
    vecs[9]  = '{0,1,1,4,7,4,1,4,1,0, 1,1,2,1,12'h028};
    vecs[10] = '{0,1,0,1,1,0,0,1,1,1, 1,1,2,1,12'h038};
    vecs[11] = '{0,0,0,0,0,0,0,0,0,1, 0,1,1,1,12'h04F};
    vecs[12] = '{0,0,0,3,0,3,1,0,0,0, 0,1,1,1,12'h04F};
    vecs[13] = '{0,1,1,3,0,3,0,3,0,0, 0,1,1,1,12'h04F};
    vecs[14] = '{0,1,1,0,6,6,1,6,0,0, 1,1,2,1,12'h04F};
    vecs[15] = '{0,0,0,0,6,6,1,6,0,1, 0,1,1,1,12'h052};
    vecs[16] = '{0,0,0,0,6,6,1,6,0,1, 0,0,0,0,12'h000};

    // Reset held for two clocks
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst.lv",   32'(logIf.log_valid), 32'd0);
    chk("rst.cnt",  32'(logIf.log_count), 32'd0);
    chk("rst.ovf",  32'(overflow),        32'd0);
    chk("rst.drop", 32'(dropCount),       32'd0);

    // Table: hazard checked before the edge, registered outputs after it
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].clr, vecs[i].iv, vecs[i].adv, vecs[i].rs1, vecs[i].rs2,
            vecs[i].er, vecs[i].ew, vecs[i].mr, vecs[i].mw, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d.hz", i), 32'(hazardNow), 32'(vecs[i].hz));
      step();
      chk($sformatf("v%0d.lv", i),  32'(logIf.log_valid), 32'(vecs[i].lv));
      chk($sformatf("v%0d.cnt", i), 32'(logIf.log_count), 32'(vecs[i].cnt));
      if (vecs[i].chkD)
        chk($sformatf("v%0d.data", i), 32'(logIf.log_data), 32'(vecs[i].data));
      chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'd0);
    end
    expSeq = 6;

    // Overflow: ten distinct hazards with the reader stalled
    for (int i = 0; i < 10; i++) begin
      hzPush(1'b1, 1'b0);
      step();
      expSeq++;
    end
    chk("ovf.cnt",  32'(logIf.log_count), 32'd8);
    chk("ovf.flag", 32'(overflow),        32'd1);
    chk("ovf.drop", 32'(dropCount),       32'd2);
    chk("ovf.head", 32'(logIf.log_data),  32'({8'd6, 4'h8}));

    // Push and pop together while full: no drop
    hzPush(1'b1, 1'b1);
    step();
    expSeq++;
    chk("full.pp.cnt",  32'(logIf.log_count), 32'd8);
    chk("full.pp.drop", 32'(dropCount),       32'd2);
    chk("full.pp.head", 32'(logIf.log_data),  32'({8'd7, 4'h8}));

    // Drop counter saturates at all-ones
    for (int i = 0; i < 260; i++) begin
      hzPush(1'b1, 1'b0);
      step();
      expSeq++;
    end
    chk("sat.drop", 32'(dropCount),       32'hFF);
    chk("sat.cnt",  32'(logIf.log_count), 32'd8);

    // Plain clear
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    chk("clr.cnt",  32'(logIf.log_count), 32'd0);
    chk("clr.ovf",  32'(overflow),        32'd0);
    chk("clr.drop", 32'(dropCount),       32'd0);

    // Three entries; the sequence number has wrapped by now
    for (int i = 0; i < 3; i++) begin
      hzPush(1'b1, 1'b0);
      step();
      expSeq++;
    end
    chk("wrap.cnt",  32'(logIf.log_count), 32'd3);
    chk("wrap.head", 32'(logIf.log_data),  32'({8'(expSeq - 3), 4'h8}));

    // Clear coincident with push and pop
    drive(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1);
    step();
    chk("clrpush.cnt",  32'(logIf.log_count), 32'd0);
    chk("clrpush.lv",   32'(logIf.log_valid), 32'd0);
    chk("clrpush.ovf",  32'(overflow),        32'd0);
    chk("clrpush.drop", 32'(dropCount),       32'd0);
    idle();
    step();
    chk("clrpush.idle", 32'(logIf.log_count), 32'd0);

    // Clear does not forget that the stalled instruction already logged
    drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0);
    step();
    expSeq++;
    hzPush(1'b0, 1'b0);
    step();
    chk("stall.cnt",  32'(logIf.log_count), 32'd1);
    chk("stall.data", 32'(logIf.log_data),  32'({8'(expSeq), 4'h8}));
    drive(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
    step();
    hzPush(1'b0, 1'b0);
    step();
    chk("stall.norelog", 32'(logIf.log_count), 32'd0);

    // Reset mid-operation drops state and the in-flight push
    hzPush(1'b1, 1'b0);
    step();
    hzPush(1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst.cnt", 32'(logIf.log_count), 32'd0);
    chk("mrst.lv",  32'(logIf.log_valid), 32'd0);
    hzPush(1'b0, 1'b0);
    step();
    chk("mrst.data", 32'(logIf.log_data), 32'h008);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

`default_nettype wire
